// File: rtl/riot_bus_arbiter_if.sv
// Bus bundle between the CPU/host address decoders, the arbiter and the RIOT.
interface riot_bus_arbiter_if;
  // CPU requester
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  // Host side-channel requester
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_err;
  // RIOT port
  logic [6:0] riot_a;
  logic [7:0] riot_din;
  logic [7:0] riot_dout;
  logic       riot_cs;
  logic       riot_cs_n;
  logic       riot_rw_n;
  logic       riot_rs_n;
  // Status
  logic       busy;
  logic       grant_host;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  riot_dout,
    output cpu_ack, cpu_rdata,
    output host_ack, host_rdata, host_err,
    output riot_a, riot_din, riot_cs, riot_cs_n, riot_rw_n, riot_rs_n,
    output busy, grant_host
  );

  // Requester / RIOT side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output riot_dout,
    input  cpu_ack, cpu_rdata,
    input  host_ack, host_rdata, host_err,
    input  riot_a, riot_din, riot_cs, riot_cs_n, riot_rw_n, riot_rs_n,
    input  busy, grant_host
  );
endinterface

// File: rtl/riot_bus_arbiter.sv
// Two-requester arbiter for the single RIOT (6532) port: CPU has priority,
// host side-channel is admitted when the CPU is quiet or after a starvation
// limit. Each access is IDLE -> ISSUE (one-cycle strobe) -> DONE (capture).
module riot_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter bit          HOST_SE_BLOCK = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  riot_bus_arbiter_if.slave  bus
);

  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t        r_state;
  logic          r_host;
  logic          r_we;
  logic          r_blocked;
  logic [CW-1:0] r_starve;

  logic       r_cpu_ack, r_host_ack, r_host_err;
  logic [7:0] r_cpu_rdata, r_host_rdata;
  logic [6:0] r_riot_a;
  logic [7:0] r_riot_din;
  logic       r_riot_cs, r_riot_cs_n, r_riot_rw_n, r_riot_rs_n;
  logic       r_busy, r_grant_host;

  logic       w_cpu_elig, w_host_elig, w_starve_hit;
  logic       w_host_win, w_cpu_win, w_host_blk;
  logic       w_sel_we;
  logic [7:0] w_sel_addr, w_sel_wdata;

  // A requester whose ack is showing this cycle is not eligible, so a held
  // request is not granted twice for one transaction. The CPU keeps the host
  // out even during its own ack cycle unless the starvation limit is hit.
  assign w_cpu_elig   = bus.cpu_req  & ~r_cpu_ack;
  assign w_host_elig  = bus.host_req & ~r_host_ack;
  assign w_starve_hit = (STARVE_LIMIT != 0) && (r_starve == LIMIT);
  assign w_host_win   = w_host_elig & (~bus.cpu_req | w_starve_hit);
  assign w_cpu_win    = w_cpu_elig & ~w_host_win;
  assign w_host_blk   = HOST_SE_BLOCK & ~bus.host_we & bus.host_addr[7] & bus.host_addr[2];

  assign w_sel_we    = w_host_win ? bus.host_we    : bus.cpu_we;
  assign w_sel_addr  = w_host_win ? bus.host_addr  : bus.cpu_addr;
  assign w_sel_wdata = w_host_win ? bus.host_wdata : bus.cpu_wdata;

  // Arbitration, access sequencing, strobe generation and read capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_host       <= 1'b0;
      r_we         <= 1'b0;
      r_blocked    <= 1'b0;
      r_starve     <= '0;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_err   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
      r_riot_a     <= '0;
      r_riot_din   <= '0;
      r_riot_cs    <= 1'b0;
      r_riot_cs_n  <= 1'b1;
      r_riot_rw_n  <= 1'b1;
      r_riot_rs_n  <= 1'b1;
      r_busy       <= 1'b0;
      r_grant_host <= 1'b0;
    end else begin
      r_cpu_ack  <= 1'b0;
      r_host_ack <= 1'b0;

      if (!bus.host_req) begin
        r_starve <= '0;
      end else if (r_state == S_IDLE) begin
        if (w_host_win)
          r_starve <= '0;
        else if (w_cpu_win && (r_starve != LIMIT))
          r_starve <= r_starve + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_host_win || w_cpu_win) begin
            r_state      <= S_ISSUE;
            r_host       <= w_host_win;
            r_we         <= w_sel_we;
            r_blocked    <= w_host_win & w_host_blk;
            r_busy       <= 1'b1;
            r_grant_host <= w_host_win;
            // A blocked host read walks the FSM without touching the RIOT.
            if (!(w_host_win && w_host_blk)) begin
              r_riot_cs   <= 1'b1;
              r_riot_cs_n <= 1'b0;
              r_riot_rs_n <= w_sel_addr[7];
              r_riot_a    <= w_sel_addr[6:0];
              r_riot_rw_n <= ~w_sel_we;
              r_riot_din  <= w_sel_wdata;
            end
          end
        end
        S_ISSUE: begin
          r_state     <= S_DONE;
          r_riot_cs   <= 1'b0;
          r_riot_cs_n <= 1'b1;
          r_riot_rw_n <= 1'b1;
          r_riot_rs_n <= 1'b1;
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_grant_host <= 1'b0;
          if (r_host) begin
            r_host_ack <= 1'b1;
            r_host_err <= r_blocked;
            if (r_blocked)
              r_host_rdata <= '0;
            else if (!r_we)
              r_host_rdata <= bus.riot_dout;
          end else begin
            r_cpu_ack <= 1'b1;
            if (!r_we)
              r_cpu_rdata <= bus.riot_dout;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_rdata = r_host_rdata;
  assign bus.host_err   = r_host_err;
  assign bus.riot_a     = r_riot_a;
  assign bus.riot_din   = r_riot_din;
  assign bus.riot_cs    = r_riot_cs;
  assign bus.riot_cs_n  = r_riot_cs_n;
  assign bus.riot_rw_n  = r_riot_rw_n;
  assign bus.riot_rs_n  = r_riot_rs_n;
  assign bus.busy       = r_busy;
  assign bus.grant_host = r_grant_host;

endmodule

// File: tb/tb_riot_bus_arbiter.sv
// Directed bench for riot_bus_arbiter with a behavioural RIOT and an
// ack-order scoreboard; a second instance covers strict CPU priority.
`define CHK(TAG, OBS, EXP) begin \
  n_checks++; \
  assert ((OBS) === (EXP)) else begin \
    n_fail++; \
    $error("FAIL %s: observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
  end \
end

module tb_riot_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  riot_bus_arbiter_if bus1();
  riot_bus_arbiter_if bus2();

  riot_bus_arbiter #(.STARVE_LIMIT(4), .HOST_SE_BLOCK(1'b1)) dut (
    .CLK(clk), .RESET(rst), .bus(bus1)
  );

  riot_bus_arbiter #(.STARVE_LIMIT(0), .HOST_SE_BLOCK(1'b0)) dut_strict (
    .CLK(clk), .RESET(rst), .bus(bus2)
  );

  // Behavioural RIOT: RAM, I/O regs, timer (/8) and interrupt flag
  logic [7:0] ram [128];
  logic [7:0] io  [128];
  logic [7:0] timer = 8'h00;
  logic [2:0] presc = 3'd0;
  logic       irq   = 1'b1;

  always @(posedge clk) begin
    presc <= presc + 3'd1;
    if (presc == 3'd7) timer <= timer - 8'd1;
    if (bus1.riot_cs && !bus1.riot_cs_n) begin
      if (!bus1.riot_rw_n) begin
        if (bus1.riot_rs_n && bus1.riot_a[4] && bus1.riot_a[2]) begin
          timer <= bus1.riot_din;
          presc <= 3'd0;
        end else if (bus1.riot_rs_n) io[bus1.riot_a]  <= bus1.riot_din;
        else                         ram[bus1.riot_a] <= bus1.riot_din;
      end else begin
        if (bus1.riot_rs_n && bus1.riot_a[2]) begin
          bus1.riot_dout <= timer;
          irq <= 1'b0;
        end else if (bus1.riot_rs_n) bus1.riot_dout <= io[bus1.riot_a];
        else                         bus1.riot_dout <= ram[bus1.riot_a];
      end
    end
  end

  // Second RIOT stand-in: read data reflects the address
  always @(posedge clk)
    if (bus2.riot_cs) bus2.riot_dout <= {1'b1, bus2.riot_a};

  // Scoreboard of expected acks in order
  typedef struct {
    logic       host;
    logic [7:0] rd;
    logic [7:0] alt;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  int   n_pulse = 0;
  int   gap     = 0;
  logic prev_cs = 1'b0;

  // Ack checker and strobe-shape checker, sampled on the falling edge
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] rd;
    if (bus1.cpu_ack || bus1.host_ack) begin
      `CHK("ack_expected", (exp_q.size() != 0), 1'b1)
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        `CHK("both_ack", (bus1.cpu_ack & bus1.host_ack), 1'b0)
        `CHK("ack_owner", bus1.host_ack, e.host)
        rd = e.host ? bus1.host_rdata : bus1.cpu_rdata;
        n_checks++;
        assert (rd === e.rd || rd === e.alt) else begin
          n_fail++;
          $error("FAIL rdata: observed=%0h expected=%0h", rd, e.rd);
        end
        if (e.host) `CHK("host_err", bus1.host_err, e.err)
      end
    end
    if (bus1.riot_cs) begin
      `CHK("cs_width_1", prev_cs, 1'b0)
      `CHK("cs_n_inverse", bus1.riot_cs_n, 1'b0)
      if (!prev_cs) begin
        if (n_pulse > 0) `CHK("cs_gap_ge2", (gap >= 2), 1'b1)
        n_pulse++;
      end
      gap = 0;
    end else begin
      gap++;
    end
    prev_cs = bus1.riot_cs;
  end

  logic [7:0] cpu_last  = 8'h00;
  logic [7:0] host_last = 8'h00;

  task automatic do_access(input logic host, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rd,
                           input logic [7:0] alt, input logic err);
    exp_t e;
    int   lat;
    logic got;
    @(negedge clk);
    e.host = host; e.err = err;
    if (we) begin
      e.rd  = host ? host_last : cpu_last;
      e.alt = e.rd;
    end else begin
      e.rd = rd; e.alt = alt;
      if (host) host_last = rd; else cpu_last = rd;
    end
    exp_q.push_back(e);
    if (host) begin
      bus1.host_we = we; bus1.host_addr = addr; bus1.host_wdata = wdata; bus1.host_req = 1'b1;
    end else begin
      bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata; bus1.cpu_req = 1'b1;
    end
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (host ? bus1.host_ack : bus1.cpu_ack) got = 1'b1;
    end
    if (host) bus1.host_req = 1'b0; else bus1.cpu_req = 1'b0;
    `CHK("ack_seen", got, 1'b1)
    `CHK("latency_3", lat, 3)
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses;
    int   n2;
    int   lat;
    logic got;
    logic host_seen;
    exp_t e;

    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.host_req = 1'b0; bus1.host_we = 1'b0; bus1.host_addr = '0; bus1.host_wdata = '0;
    bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    bus2.host_req = 1'b0; bus2.host_we = 1'b0; bus2.host_addr = '0; bus2.host_wdata = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    `CHK("rst_cpu_ack", bus1.cpu_ack, 1'b0)
    `CHK("rst_host_ack", bus1.host_ack, 1'b0)
    `CHK("rst_host_err", bus1.host_err, 1'b0)
    `CHK("rst_busy", bus1.busy, 1'b0)
    `CHK("rst_grant_host", bus1.grant_host, 1'b0)
    `CHK("rst_cpu_rdata", bus1.cpu_rdata, 8'h00)
    `CHK("rst_host_rdata", bus1.host_rdata, 8'h00)
    `CHK("rst_cs", bus1.riot_cs, 1'b0)
    `CHK("rst_cs_n", bus1.riot_cs_n, 1'b1)
    `CHK("rst_rw_n", bus1.riot_rw_n, 1'b1)
    `CHK("rst_rs_n", bus1.riot_rs_n, 1'b1)
    `CHK("rst_a", bus1.riot_a, 7'h00)
    `CHK("rst_din", bus1.riot_din, 8'h00)

    // CPU I/O write then read back
    do_access(1'b0, 1'b1, 8'h80, 8'h5A, 8'h00, 8'h00, 1'b0);
    `CHK("t1_io_written", io[0], 8'h5A)
    do_access(1'b0, 1'b0, 8'h80, 8'h00, 8'h5A, 8'h5A, 1'b0);

    // Preload RAM from both sides; host read-back
    do_access(1'b0, 1'b1, 8'h10, 8'h3C, 8'h00, 8'h00, 1'b0);
    do_access(1'b1, 1'b1, 8'h11, 8'hC3, 8'h00, 8'h00, 1'b0);
    do_access(1'b1, 1'b0, 8'h11, 8'h00, 8'hC3, 8'hC3, 1'b0);

    // Simultaneous requests with CPU held: C,C,C,C,H,C
    @(negedge clk);
    e.err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.host = 1'b0; e.rd = 8'h3C; e.alt = 8'h3C; exp_q.push_back(e);
    end
    e.host = 1'b1; e.rd = 8'hC3; e.alt = 8'hC3; exp_q.push_back(e);
    e.host = 1'b0; e.rd = 8'h3C; e.alt = 8'h3C; exp_q.push_back(e);
    bus1.cpu_we = 1'b0; bus1.cpu_addr = 8'h10;
    bus1.host_we = 1'b0; bus1.host_addr = 8'h11;
    bus1.cpu_req = 1'b1; bus1.host_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus1.host_ack) got = 1'b1;
    end
    bus1.host_req = 1'b0;
    `CHK("t2_host_ack_seen", got, 1'b1)
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack) got = 1'b1;
    end
    bus1.cpu_req = 1'b0;
    `CHK("t2_cpu_ack_seen", got, 1'b1)
    cpu_last = 8'h3C; host_last = 8'hC3;
    repeat (4) @(negedge clk);
    `CHK("t2_queue_drained", exp_q.size(), 0)

    // Host timer read is blocked: no strobe, err=1, data 0, irq untouched
    pulses = n_pulse;
    do_access(1'b1, 1'b0, 8'h84, 8'h00, 8'h00, 8'h00, 1'b1);
    `CHK("t3_no_cs_pulse", n_pulse, pulses)
    `CHK("t3_irq_kept", irq, 1'b1)

    // Host timer write passes; CPU timer read sees it
    do_access(1'b1, 1'b1, 8'h95, 8'h10, 8'h00, 8'h00, 1'b0);
    do_access(1'b0, 1'b0, 8'h84, 8'h00, 8'h10, 8'h0F, 1'b0);
    `CHK("t4_irq_cleared_by_cpu", irq, 1'b0)

    // Reset during ISSUE discards the access
    @(negedge clk);
    bus1.cpu_we = 1'b0; bus1.cpu_addr = 8'h10; bus1.cpu_req = 1'b1;
    @(negedge clk);
    `CHK("t5_in_issue_busy", bus1.busy, 1'b1)
    `CHK("t5_in_issue_cs", bus1.riot_cs, 1'b1)
    rst = 1'b1; bus1.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    `CHK("t5_busy_cleared", bus1.busy, 1'b0)
    `CHK("t5_cs_low", bus1.riot_cs, 1'b0)
    `CHK("t5_cs_n_high", bus1.riot_cs_n, 1'b1)
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack) got = 1'b1;
    end
    `CHK("t5_no_ack", got, 1'b0)
    `CHK("t5_rdata_reset", bus1.cpu_rdata, 8'h00)
    cpu_last = 8'h00; host_last = 8'h00;
    do_access(1'b0, 1'b1, 8'h05, 8'hA5, 8'h00, 8'h00, 1'b0);
    do_access(1'b0, 1'b0, 8'h05, 8'h00, 8'hA5, 8'hA5, 1'b0);

    // Strict CPU priority: host waits until cpu_req falls; no SE block
    @(negedge clk);
    bus2.cpu_we = 1'b0; bus2.cpu_addr = 8'h01;
    bus2.host_we = 1'b0; bus2.host_addr = 8'h84;
    bus2.cpu_req = 1'b1; bus2.host_req = 1'b1;
    host_seen = 1'b0; n2 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus2.grant_host || bus2.host_ack) host_seen = 1'b1;
      if (bus2.cpu_ack) begin
        n2++;
        `CHK("t6_cpu_rdata", bus2.cpu_rdata, 8'h81)
      end
    end
    `CHK("t6_host_never_granted", host_seen, 1'b0)
    `CHK("t6_cpu_progress", (n2 >= 5), 1'b1)
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus2.cpu_ack) got = 1'b1;
    end
    bus2.cpu_req = 1'b0;
    `CHK("t6_cpu_ack_seen", got, 1'b1)
    got = 1'b0; lat = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus2.host_ack) got = 1'b1;
    end
    bus2.host_req = 1'b0;
    `CHK("t6_host_ack_seen", got, 1'b1)
    `CHK("t6_host_latency", lat, 3)
    `CHK("t6_host_rdata", bus2.host_rdata, 8'h84)
    `CHK("t6_host_err", bus2.host_err, 1'b0)

    repeat (4) @(negedge clk);
    `CHK("final_queue_empty", exp_q.size(), 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
